// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its scoreboard.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Register x0 is hard-wired to zero, so writes to it are never performed.
   localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

   // Which requester currently wins a tie for the write port.
   typedef enum logic {
      PRI_LD = 1'b0,
      PRI_EX = 1'b1
   } arb_state_e;

endpackage : wb_arbiter_pkg

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// producer is issued and cleared when its result is written back.
module wb_scoreboard
   import wb_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  set,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] q_a,
   input  logic [REG_ADDR_W-1:0] q_b,
   output logic                  busy_a,
   output logic                  busy_b
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;

   // Clear before set so that a new producer issued in the same cycle as the
   // old one retires keeps its register marked busy; x0 can never be pending.
   always_comb begin
      pending_next = pending;
      if (clr) begin
         pending_next[clr_idx] = 1'b0;
      end
      if (set) begin
         pending_next[set_idx] = 1'b1;
      end
      pending_next[X0_IDX] = 1'b0;
   end

   // Scoreboard register; flush wipes every outstanding producer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Query ports read the stored bits directly, without forwarding.
   always_comb begin
      busy_a = pending[q_a];
      busy_b = pending[q_b];
   end

endmodule : wb_scoreboard

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// execute stage and the load unit, with an anti-starvation counter for execute
// and a pending-write scoreboard for decode hazard checks.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic [REG_ADDR_W-1:0] q_rs1,
   input  logic [REG_ADDR_W-1:0] q_rs2,
   output logic                  busy_rs1,
   output logic                  busy_rs2,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [XLEN-1:0]       ex_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_data,
   input  logic                  flush,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]       wr_data
);

   localparam int                WAIT_W  = 4;
   localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

   arb_state_e            state;
   arb_state_e            state_next;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [WAIT_W-1:0]     wait_next;
   logic                  ex_xfer;
   logic                  ld_xfer;
   logic                  wr_en_next;
   logic [REG_ADDR_W-1:0] wr_addr_next;
   logic [XLEN-1:0]       wr_data_next;
   logic                  sb_set;

   // Grant logic depends only on valids, flush and the priority state, so a
   // requester never sees ready ripple from its own data.
   always_comb begin
      ex_ready = 1'b0;
      ld_ready = 1'b0;
      if (!flush) begin
         case (state)
            PRI_LD: begin
               ld_ready = ld_valid;
               ex_ready = ex_valid && !ld_valid;
            end
            PRI_EX: begin
               ex_ready = ex_valid;
               ld_ready = ld_valid && !ex_valid;
            end
            default: begin
               ld_ready = ld_valid;
               ex_ready = ex_valid && !ld_valid;
            end
         endcase
      end
   end

   // Starvation counter and priority state: execute takes priority as soon as
   // it has been blocked MAX_WAIT times, and hands it back after one transfer.
   always_comb begin
      ex_xfer    = ex_valid && ex_ready;
      ld_xfer    = ld_valid && ld_ready;
      wait_next  = wait_cnt;
      state_next = state;
      if (flush) begin
         wait_next  = '0;
         state_next = PRI_LD;
      end else begin
         if (ex_xfer) begin
            wait_next = '0;
         end else if (ex_valid && (wait_cnt != MAX_CNT)) begin
            wait_next = wait_cnt + 1'b1;
         end
         case (state)
            PRI_LD: begin
               if (wait_next == MAX_CNT) begin
                  state_next = PRI_EX;
               end
            end
            PRI_EX: begin
               if (ex_xfer) begin
                  state_next = PRI_LD;
               end
            end
            default: state_next = PRI_LD;
         endcase
      end
   end

   // Select what the write port performs next cycle; x0 targets and anything
   // granted during a flush are dropped.
   always_comb begin
      wr_en_next   = 1'b0;
      wr_addr_next = '0;
      wr_data_next = '0;
      if (!flush) begin
         if (ex_xfer && (ex_rd != X0_IDX)) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ex_rd;
            wr_data_next = ex_data;
         end else if (ld_xfer && (ld_rd != X0_IDX)) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ld_rd;
            wr_data_next = ld_data;
         end
      end
   end

   // Arbitration state and the registered write port.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= PRI_LD;
         wait_cnt <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         wr_en    <= wr_en_next;
         wr_addr  <= wr_addr_next;
         wr_data  <= wr_data_next;
      end
   end

   assign sb_set = iss_valid && (iss_rd != X0_IDX);

   wb_scoreboard u_scoreboard (
      .clk     (clk),
      .rstn    (rstn),
      .set     (sb_set),
      .set_idx (iss_rd),
      .clr     (wr_en),
      .clr_idx (wr_addr),
      .flush   (flush),
      .q_a     (q_rs1),
      .q_b     (q_rs2),
      .busy_a  (busy_rs1),
      .busy_b  (busy_rs2)
   );

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_wb_arbiter;

   localparam int XLEN     = 32;
   localparam int MAX_WAIT = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [4:0]      q_rs1;
   logic [4:0]      q_rs2;
   logic            busy_rs1;
   logic            busy_rs2;
   logic            ex_valid;
   logic            ex_ready;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            flush;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit              m_busy [32];
   bit              m_ex_pri;
   int              m_blocked;
   bit              m_wr_en;
   int              m_wr_addr;
   logic [XLEN-1:0] m_wr_data;

   // Ready values sampled during the last applied cycle
   logic s_ex_ready;
   logic s_ld_ready;

   wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .q_rs1    (q_rs1),
      .q_rs2    (q_rs2),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2),
      .ex_valid (ex_valid),
      .ex_ready (ex_ready),
      .ex_rd    (ex_rd),
      .ex_data  (ex_data),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_rd    (ld_rd),
      .ld_data  (ld_data),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_ex_pri  = 1'b0;
      m_blocked = 0;
      m_wr_en   = 1'b0;
      m_wr_addr = 0;
      m_wr_data = '0;
   endtask

   // Drive one cycle of inputs, check combinational outputs mid-cycle, then
   // advance the model across the clock edge and check the write port.
   task automatic applyStimulus(input bit iv, input logic [4:0] ird,
                                input bit ev, input logic [4:0] erd, input logic [31:0] ed,
                                input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input bit fl, input logic [4:0] q1, input logic [4:0] q2);
      bit e_ex, e_ld, gex, gld;
      @(negedge clk);
      iss_valid = iv;  iss_rd = ird;
      ex_valid  = ev;  ex_rd  = erd; ex_data = ed;
      ld_valid  = lv;  ld_rd  = lrd; ld_data = ld;
      flush     = fl;  q_rs1  = q1;  q_rs2   = q2;
      #1;
      if (fl) begin
         e_ex = 1'b0; e_ld = 1'b0;
      end else if (m_ex_pri) begin
         e_ex = ev; e_ld = lv && !ev;
      end else begin
         e_ld = lv; e_ex = ev && !lv;
      end
      checkOutput("ex_ready", {31'd0, ex_ready}, {31'd0, e_ex});
      checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, e_ld});
      checkOutput("busy_rs1", {31'd0, busy_rs1}, {31'd0, m_busy[q1]});
      checkOutput("busy_rs2", {31'd0, busy_rs2}, {31'd0, m_busy[q2]});
      s_ex_ready = ex_ready;
      s_ld_ready = ld_ready;
      @(posedge clk);
      gex = ev && e_ex;
      gld = lv && e_ld;
      if (fl) begin
         modelReset();
      end else begin
         if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
         if (iv && ird != 0) m_busy[ird] = 1'b1;
         if (gex) m_blocked = 0;
         else if (ev) m_blocked = (m_blocked + 1 > MAX_WAIT) ? MAX_WAIT : m_blocked + 1;
         if (m_ex_pri && gex) m_ex_pri = 1'b0;
         else if (!m_ex_pri && m_blocked == MAX_WAIT) m_ex_pri = 1'b1;
         m_wr_en = 1'b0;
         if (gex && erd != 0) begin
            m_wr_en = 1'b1; m_wr_addr = int'(erd); m_wr_data = ed;
         end else if (gld && lrd != 0) begin
            m_wr_en = 1'b1; m_wr_addr = int'(lrd); m_wr_data = ld;
         end
      end
      #1;
      checkOutput("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
      if (m_wr_en) begin
         checkOutput("wr_addr", {27'd0, wr_addr}, 32'(m_wr_addr));
         checkOutput("wr_data", wr_data, m_wr_data);
      end
   endtask

   task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
   endtask

   // Randomized traffic; requesters hold their request until it transfers and
   // decode never issues to a register the model already shows as busy.
   task automatic randomTraffic(input int cycles);
      bit p_ev, p_lv, iv, fl;
      logic [4:0] p_erd, p_lrd, ird;
      logic [31:0] p_ed, p_ld;
      p_ev = 0; p_lv = 0; p_erd = 0; p_lrd = 0; p_ed = 0; p_ld = 0;
      for (int c = 0; c < cycles; c++) begin
         if (!p_ev && $urandom_range(0, 99) < 60) begin
            p_ev = 1; p_erd = 5'($urandom); p_ed = $urandom;
         end
         if (!p_lv && $urandom_range(0, 99) < 60) begin
            p_lv = 1; p_lrd = 5'($urandom); p_ld = $urandom;
         end
         ird = 5'($urandom);
         iv  = ($urandom_range(0, 99) < 30) && !m_busy[ird];
         fl  = ($urandom_range(0, 99) < 3);
         applyStimulus(iv, ird, p_ev, p_erd, p_ed, p_lv, p_lrd, p_ld, fl,
                       5'($urandom), 5'($urandom));
         if (p_ev && s_ex_ready) p_ev = 0;
         if (p_lv && s_ld_ready) p_lv = 0;
      end
   endtask

   initial begin
      int ld_cnt;
      rstn = 1'b0;
      iss_valid = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
      ex_valid = 0; ex_rd = 0; ex_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0; flush = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
      checkOutput("reset_wr_data", wr_data, 32'd0);
      checkOutput("reset_busy", {31'd0, busy_rs1}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      $display("[TB] single execute write");
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      idle(5, 0);
      checkOutput("busy_after_issue", {31'd0, busy_rs1}, 32'd1);
      idle(5, 0);
      applyStimulus(0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, 5, 0);
      checkOutput("single_ex_ready", {31'd0, s_ex_ready}, 32'd1);
      checkOutput("single_wr_addr", {27'd0, wr_addr}, 32'd5);
      checkOutput("single_wr_data", wr_data, 32'h1234);
      idle(5, 0);
      checkOutput("busy_after_write", {31'd0, busy_rs1}, 32'd0);

      $display("[TB] contention");
      idle(0, 0);
      ld_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 1, 20, 32'hE0, 1, 5'(10 + ld_cnt), 32'(100 + ld_cnt), 0, 0, 0);
         checkOutput("contention_grant", {31'd0, s_ex_ready}, (i == 4) ? 32'd1 : 32'd0);
         checkOutput("contention_addr", {27'd0, wr_addr}, (i == 4) ? 32'd20 : 32'(10 + ld_cnt));
         if (s_ld_ready) ld_cnt++;
      end

      $display("[TB] x0 write");
      applyStimulus(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_ready", {31'd0, s_ex_ready}, 32'd1);
      checkOutput("x0_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("x0_wr_addr", {27'd0, wr_addr}, 32'd0);

      $display("[TB] same-cycle set and clear");
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7);
      applyStimulus(0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 7);
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7);
      idle(0, 7);
      checkOutput("set_wins_busy", {31'd0, busy_rs2}, 32'd1);
      applyStimulus(0, 0, 1, 7, 32'h78, 0, 0, 0, 0, 0, 7);
      idle(0, 7);
      checkOutput("set_wins_cleared", {31'd0, busy_rs2}, 32'd0);

      $display("[TB] flush");
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 9);
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 3, 9);
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 3, 9);
      checkOutput("flush_ld_ready", {31'd0, s_ld_ready}, 32'd0);
      checkOutput("flush_wr_en", {31'd0, wr_en}, 32'd0);
      idle(3, 9);
      checkOutput("flush_busy1", {31'd0, busy_rs1}, 32'd0);
      checkOutput("flush_busy2", {31'd0, busy_rs2}, 32'd0);

      $display("[TB] random traffic");
      randomTraffic(600);

      $display("[TB] reset mid-stream");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 12, 0, 0, 0, 0, 0, 0, 0, 12, 0);
      applyStimulus(1, 13, 0, 0, 0, 0, 0, 0, 0, 12, 0);
      for (int i = 0; i < MAX_WAIT; i++) begin
         applyStimulus(0, 0, 1, 21, 32'hAA, 1, (i == MAX_WAIT - 1) ? 5'd13 : 5'd0, 32'hBB, 0, 12, 0);
      end
      checkOutput("pre_reset_wr_en", {31'd0, wr_en}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async_reset_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("async_reset_busy", {31'd0, busy_rs1}, 32'd0);
      modelReset();
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(0, 0, 1, 21, 32'hAA, 1, 5'd14, 32'hCC, 0, 12, 13);
      checkOutput("post_reset_ld_pri", {31'd0, s_ld_ready}, 32'd1);
      checkOutput("post_reset_ex_blocked", {31'd0, s_ex_ready}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "[TB] timeout");
   end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Schedules the register file's single write port between the execute stage (ALU/CSR/LUI/AUIPC/JAL results) and the variable-latency load unit.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards against in-flight destinations.
- Sits between the execute/load units and the register-file write port.
- Drives a registered write enable, address and data; x0 writes are suppressed here.

Parameters:
- XLEN, 32, data width.
- MAX_WAIT, 4, consecutive cycles ex may be blocked before it gains priority (1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- iss_valid  in  1  decode issues an instruction that writes a register
- iss_rd  in  5  destination of the issued instruction
- q_rs1  in  5  decode source 1 query
- q_rs2  in  5  decode source 2 query
- busy_rs1  out  1  q_rs1 has a pending write
- busy_rs2  out  1  q_rs2 has a pending write
- ex_valid  in  1  execute result available
- ex_ready  out  1  execute result accepted this cycle
- ex_rd  in  5  execute destination
- ex_data  in  XLEN  execute result
- ld_valid  in  1  load data available
- ld_ready  out  1  load data accepted this cycle
- ld_rd  in  5  load destination
- ld_data  in  XLEN  load data
- flush  in  1  discard all pending-write state
- wr_en  out  1  register-file write enable
- wr_addr  out  5  register-file write address
- wr_data  out  XLEN  register-file write data

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, scoreboard all clear, state=PRI_LD, wait counter=0.
- Handshake:
  - A transfer occurs on valid&&ready.
  - ready is combinational from the valid inputs and state only; it never depends on the data inputs.
  - A requester must hold valid, rd and data stable until the transfer.
- Arbitration, one grant per cycle:
  - State PRI_LD: ld_ready=ld_valid; ex_ready=ex_valid&&!ld_valid.
  - State PRI_EX: ex_ready=ex_valid; ld_ready=ld_valid&&!ex_valid.
- Wait counter:
  - Increments on each cycle with ex_valid&&!ex_ready, saturating at MAX_WAIT.
  - Clears on an ex transfer.
- State transitions:
  - PRI_LD -> PRI_EX when the counter reaches MAX_WAIT.
  - PRI_EX -> PRI_LD on the cycle after an ex transfer.
  - Otherwise the state holds.
- Write port, latency 1:
  - The transfer in cycle N produces wr_en=1 with wr_addr/wr_data in cycle N+1.
  - wr_en=0 when there is no transfer.
  - A transfer with rd==0 is accepted but gives wr_en=0 and wr_addr=0, and does not touch the scoreboard.
- Scoreboard: 32 bits, bit 0 hard-wired 0.
  - Set: iss_valid sets bit iss_rd.
  - Clear: wr_en clears bit wr_addr at the clock edge.
  - Simultaneous set and clear of the same index: the bit stays set, because a new producer is pending.
  - A second issue to an already-busy rd keeps the bit set. It clears at the first matching write; decode must not issue a second producer to a busy rd.
- Busy outputs:
  - busy_rsN = scoreboard[q_rsN] || (wr_en && wr_addr==q_rsN && 0).
  - That is, purely combinational from the current scoreboard, with no forwarding; the write lands in the register file at the same edge the bit clears.
- flush (synchronous):
  - Clears the scoreboard, counter and state (to PRI_LD).
  - Forces wr_en=0 next cycle, so a grant in the flush cycle is dropped.
  - ready outputs are 0 during flush.
  - iss_valid in the flush cycle is ignored.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; a pending write is lost.

Decomposition:
- Shared package:
  - state enum {PRI_LD, PRI_EX}
  - REG_ADDR_W=5, NUM_REGS=32
  - the x0 index constant
- Sub-module wb_scoreboard:
  - inputs: set/set_idx, clr/clr_idx, flush
  - outputs: two query read ports
  - instantiated once.

Test Plan:
- Reset mid-stream: assert rstn=0 with wr_en=1 pending -> wr_en=0 and busy_rs1=0 immediately; after release, state=PRI_LD.
- Single ex write:
  - Stimulus: iss rd=5, then ex_valid rd=5 data=0x1234 at cycle 3.
  - Expect: ex_ready=1 at cycle 3; wr_en=1, wr_addr=5, wr_data=0x1234 at cycle 4.
  - Expect: busy for q_rs1=5 is 1 in cycles 1..4 and 0 from cycle 5.
- Contention:
  - Stimulus: ld_valid and ex_valid both held with MAX_WAIT=4.
  - Expect: ld granted for 4 cycles, then ex granted in cycle 5, then ld priority resumes.
  - Expect: wr_addr sequence matches grant order.
- x0 write: ex_valid rd=0 data=0xFFFFFFFF -> ex_ready=1, wr_en stays 0, scoreboard unchanged.
- Same-cycle set/clear:
  - Stimulus: wr_en for rd=7 completes while iss_valid rd=7.
  - Expect: busy for q_rs2=7 remains 1 until the next rd=7 write.
- Flush:
  - Stimulus: rd=3 and rd=9 busy, flush with ld_valid asserted.
  - Expect: ld_ready=0; next cycle wr_en=0 and all busy bits 0.
